// File: rtl/axi_txn_monitor.sv
// Passive AXI AW/AR address-channel monitor: sticky decode-error flags, 4-deep SID history
// and transaction counters per channel. Define TXN_CNT_SATURATE_EN for saturating counters.

module axi_txn_monitor_chan #(
  parameter int SID_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_en,
  input  logic             clr_cnt,
  input  logic             clr_err,
  input  logic             valid,
  input  logic             ready,
  input  logic [SID_W-1:0] sid,
  input  logic             decode_err,
  output logic             err_flag,
  output logic [SID_W-1:0] sid_buf0,
  output logic [SID_W-1:0] sid_buf1,
  output logic [SID_W-1:0] sid_buf2,
  output logic [SID_W-1:0] sid_buf3,
  output logic [CNT_W-1:0] count
);

  logic                  hs;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [3:0][SID_W-1:0] sid_q, sid_d;

  assign hs = valid & ready;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    sid_d = sid_q;
    if (mon_en) begin
      // A clear coinciding with a handshake still counts that handshake.
      if (clr_cnt) begin
        cnt_d = hs ? CNT_W'(1) : '0;
      end else if (hs) begin
`ifdef TXN_CNT_SATURATE_EN
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
`else
        cnt_d = cnt_q + CNT_W'(1);
`endif
      end
      if (hs && decode_err) begin
        err_d = 1'b1;
      end else if (clr_err) begin
        err_d = 1'b0;
      end
      if (hs) begin
        sid_d[3] = sid_q[2];
        sid_d[2] = sid_q[1];
        sid_d[1] = sid_q[0];
        sid_d[0] = sid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      sid_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      sid_q <= sid_d;
    end
  end

  assign count    = cnt_q;
  assign err_flag = err_q;
  assign sid_buf0 = sid_q[0];
  assign sid_buf1 = sid_q[1];
  assign sid_buf2 = sid_q[2];
  assign sid_buf3 = sid_q[3];

endmodule

module axi_txn_monitor #(
  parameter int SID_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_en,
  input  logic             clr_cnt,
  input  logic             clr_err,
  input  logic             aw_valid,
  input  logic             aw_ready,
  input  logic [SID_W-1:0] aw_sid,
  input  logic             aw_decode_err,
  input  logic             ar_valid,
  input  logic             ar_ready,
  input  logic [SID_W-1:0] ar_sid,
  input  logic             ar_decode_err,
  output logic             aw_decode_err_reg,
  output logic             ar_decode_err_reg,
  output logic [SID_W-1:0] aw_sid_buffer0,
  output logic [SID_W-1:0] aw_sid_buffer1,
  output logic [SID_W-1:0] aw_sid_buffer2,
  output logic [SID_W-1:0] aw_sid_buffer3,
  output logic [SID_W-1:0] ar_sid_buffer0,
  output logic [SID_W-1:0] ar_sid_buffer1,
  output logic [SID_W-1:0] ar_sid_buffer2,
  output logic [SID_W-1:0] ar_sid_buffer3,
  output logic [CNT_W-1:0] aw_transation_count,
  output logic [CNT_W-1:0] ar_transation_count
);

  axi_txn_monitor_chan #(.SID_W(SID_W), .CNT_W(CNT_W)) u_aw (
    .clk        (clk),
    .rst_n      (rst_n),
    .mon_en     (mon_en),
    .clr_cnt    (clr_cnt),
    .clr_err    (clr_err),
    .valid      (aw_valid),
    .ready      (aw_ready),
    .sid        (aw_sid),
    .decode_err (aw_decode_err),
    .err_flag   (aw_decode_err_reg),
    .sid_buf0   (aw_sid_buffer0),
    .sid_buf1   (aw_sid_buffer1),
    .sid_buf2   (aw_sid_buffer2),
    .sid_buf3   (aw_sid_buffer3),
    .count      (aw_transation_count)
  );

  axi_txn_monitor_chan #(.SID_W(SID_W), .CNT_W(CNT_W)) u_ar (
    .clk        (clk),
    .rst_n      (rst_n),
    .mon_en     (mon_en),
    .clr_cnt    (clr_cnt),
    .clr_err    (clr_err),
    .valid      (ar_valid),
    .ready      (ar_ready),
    .sid        (ar_sid),
    .decode_err (ar_decode_err),
    .err_flag   (ar_decode_err_reg),
    .sid_buf0   (ar_sid_buffer0),
    .sid_buf1   (ar_sid_buffer1),
    .sid_buf2   (ar_sid_buffer2),
    .sid_buf3   (ar_sid_buffer3),
    .count      (ar_transation_count)
  );

endmodule
